// File: rtl/comparador_serial_lsb.sv
// Bit-serial unsigned magnitude comparator, LSB first, with a start/done handshake.
// One bit is scanned per cycle, and a later (more significant) differing bit overrides the earlier verdict.
module comparador_serial_lsb #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         listo,
  output logic         valido,
  output logic         mayor,
  output logic         igual,
  output logic         menor
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  typedef enum logic [1:0] {REPOSO, COMPARA, FIN} estado_t;

  estado_t       estado, estado_sig;
  logic [N-1:0]  sa, sb;
  logic [CW-1:0] cnt;
  logic [1:0]    pq, pq_act, pq_sig;
  logic          ultimo;

  // pq: 01 equal so far, 10 A>B, 00 A<B; 11 cannot occur and decodes as equal
  always_comb begin
    pq_act = (pq == 2'b11) ? 2'b01 : pq;
    pq_sig = pq_act;
    if (sa[0] != sb[0]) pq_sig = sa[0] ? 2'b10 : 2'b00;
  end

  assign ultimo = (cnt == ULTIMO);

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (inicio) estado_sig = COMPARA;
      COMPARA: if (ultimo) estado_sig = FIN;
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      pq    <= 2'b01;
      mayor <= 1'b0;
      igual <= 1'b0;
      menor <= 1'b0;
    end else begin
      case (estado)
        REPOSO: if (inicio) begin
          sa  <= A;
          sb  <= B;
          cnt <= '0;
          pq  <= 2'b01;
        end
        COMPARA: begin
          pq  <= pq_sig;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (ultimo) begin
            mayor <= (pq_sig == 2'b10);
            igual <= (pq_sig == 2'b01);
            menor <= (pq_sig == 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

  assign listo  = (estado == REPOSO);
  assign valido = (estado == FIN);

endmodule

// File: tb/tb_comparador_serial_lsb.sv
// Self-checking bench for comparador_serial_lsb: table vectors, random vs. a magnitude model,
// and hand sequences for ignored starts, mid-run reset, back-to-back and N=1.
module tb_comparador_serial_lsb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       ini8, listo8, valido8, mayor8, igual8, menor8;
  logic [7:0] a8, b8;
  logic       ini1, listo1, valido1, mayor1, igual1, menor1;
  logic [0:0] a1, b1;

  comparador_serial_lsb #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .inicio(ini8), .A(a8), .B(b8),
    .listo(listo8), .valido(valido8), .mayor(mayor8), .igual(igual8), .menor(menor8));

  comparador_serial_lsb #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(ini1), .A(a1), .B(b1),
    .listo(listo1), .valido(valido1), .mayor(mayor1), .igual(igual1), .menor(menor1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: {mayor,igual,menor} straight from integer magnitude
  function automatic logic [2:0] modelo(input int unsigned a, input int unsigned b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_listo"}, 32'(listo8), 1);
    a8 = a; b8 = b; ini8 = 1'b1;
    @(posedge clk); #1;
    ini8 = 1'b0;
    a8 = ~a; b8 = a;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) chk({nm, "_busy"}, 32'(listo8), 0);
      if (valido8) begin lat = i; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 9);
    chk({nm, "_res"}, 32'({mayor8, igual8, menor8}), 32'(exp));
    @(negedge clk);
    chk({nm, "_after"}, 32'({valido8, listo8}), 32'b01);
  endtask

  task automatic run1(input logic a, input logic b, input logic [2:0] exp, input string nm);
    int lat;
    @(negedge clk);
    a1 = a; b1 = b; ini1 = 1'b1;
    @(posedge clk); #1;
    ini1 = 1'b0;
    a1 = ~a; b1 = ~b;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (valido1) begin lat = i; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 2);
    chk({nm, "_res"}, 32'({mayor1, igual1, menor1}), 32'(exp));
    @(negedge clk);
    chk({nm, "_after"}, 32'({valido1, listo1}), 32'b01);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t t1[4];
    logic [7:0] ra, rb;
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic [2:0] pr[3];
    logic [2:0] got_q[$];
    int acc[3];
    int idx, pulses, mism;
    logic aceptar;

    tbl[0] = '{8'hA5, 8'hA5, 3'b010};
    tbl[1] = '{8'h80, 8'h7F, 3'b100};
    tbl[2] = '{8'h01, 8'h02, 3'b001};
    tbl[3] = '{8'h10, 8'h10, 3'b010};
    tbl[4] = '{8'hFF, 8'hFE, 3'b100};
    tbl[5] = '{8'h00, 8'h00, 3'b010};
    tbl[6] = '{8'h00, 8'hFF, 3'b001};
    tbl[7] = '{8'h7F, 8'h80, 3'b001};
    t1[0] = '{8'h0, 8'h0, 3'b010};
    t1[1] = '{8'h0, 8'h1, 3'b001};
    t1[2] = '{8'h1, 8'h0, 3'b100};
    t1[3] = '{8'h1, 8'h1, 3'b010};

    rst_n = 1'b0; ini8 = 1'b0; a8 = '0; b8 = '0; ini1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset8", 32'({listo8, valido8, mayor8, igual8, menor8}), 32'b10000);
    chk("reset1", 32'({listo1, valido1, mayor1, igual1, menor1}), 32'b10000);

    foreach (tbl[i]) run8(tbl[i].a, tbl[i].b, tbl[i].res, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 4 == 0) rb = ra;
      if (i % 4 == 1) rb = ra ^ (8'h01 << (i % 8));
      run8(ra, rb, modelo(ra, rb), $sformatf("rnd%0d", i));
    end

    // starts issued while busy must be dropped, and the result must then hold
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h10; ini8 = 1'b1;
    @(posedge clk); #1;
    ini8 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (valido8) pulses++;
      if (i >= 2 && i <= 5) begin ini8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; end
      else ini8 = 1'b0;
    end
    chk("ign_pulses", 32'(pulses), 1);
    chk("ign_res", 32'({mayor8, igual8, menor8}), 32'b010);
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({mayor8, igual8, menor8} !== 3'b010 || valido8 !== 1'b0) mism++;
    end
    chk("hold", 32'(mism), 0);

    // reset sampled at edge k+4 aborts the run silently
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; ini8 = 1'b1;
    @(posedge clk); #1;
    ini8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'({listo8, valido8, mayor8, igual8, menor8}), 32'b10000);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valido8) pulses++;
    end
    chk("abort_novalid", 32'(pulses), 0);
    run8(8'h03, 8'h03, 3'b010, "post_abort");

    // inicio held high: accepted every N+2 cycles
    pa[0] = 8'hFF; pb[0] = 8'hFE; pr[0] = 3'b100;
    pa[1] = 8'h00; pb[1] = 8'h00; pr[1] = 3'b010;
    pa[2] = 8'h00; pb[2] = 8'hFF; pr[2] = 3'b001;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    @(negedge clk);
    idx = 0; a8 = pa[0]; b8 = pb[0]; ini8 = 1'b1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (valido8) got_q.push_back({mayor8, igual8, menor8});
      aceptar = listo8 && ini8;
      if (aceptar) begin acc[idx] = cyc; idx++; end
      @(posedge clk); #1;
      if (aceptar) begin
        if (idx < 3) begin a8 = pa[idx]; b8 = pb[idx]; end
        else ini8 = 1'b0;
      end
    end
    ini8 = 1'b0;
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 10);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 10);
    chk("b2b_count", 32'(got_q.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_res%0d", i), (got_q.size() > i) ? 32'(got_q[i]) : 32'hDEAD, 32'(pr[i]));

    foreach (t1[i]) run1(t1[i].a[0], t1[i].b[0], t1[i].res, $sformatf("n1_%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparador_serial_lsb.md
# comparador_serial_lsb

Sequential magnitude comparator for two unsigned N-bit words. It scans the words bit-serially from LSB to MSB, the opposite direction of the combinational MSB-first iterative comparison network built from `celdaTipica`. It uses the same two-bit state variables p,q and the same starting state 01. It sits beside the combinational comparator as the area-reduced, multi-cycle alternative, with a start/done handshake toward the controlling logic.

## Interface
- `N`, default 8, word width in bits (N ≥ 1).

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `inicio`  input  1  start request; sampled only while `listo`=1.
- `A`  input  N  first operand, unsigned; captured on an accepted `inicio`.
- `B`  input  N  second operand, unsigned; captured on an accepted `inicio`.
- `listo`  output  1  idle, able to accept `inicio`.
- `valido`  output  1  one-cycle pulse; result outputs are fresh.
- `mayor`  output  1  A > B.
- `igual`  output  1  A = B.
- `menor`  output  1  A < B.

## Operation
- Internal comparison state pq has three legal values:
  - 01 means equal so far.
  - 10 means A > B so far.
  - 00 means A < B so far.
  - 11 is unreachable; if it is ever decoded, treat it as 01.
- FSM states: REPOSO, COMPARA, FIN.
- REPOSO: `listo`=1. An `inicio`=1 at an edge does the following:
  - loads shift registers SA←A and SB←B;
  - sets bit counter ←0 and pq←01;
  - moves the FSM to COMPARA.
- COMPARA: one bit per cycle, taking a=SA[0] and b=SB[0].
  - If a≠b, pq ← (a ? 10 : 00). The higher-significance bit overrides everything below it.
  - If a=b, pq is unchanged.
  - SA and SB shift right by 1; the counter increments.
  - The edge that processes bit N-1 moves the FSM to FIN. On that same edge, `mayor`/`igual`/`menor` load from the final pq as one-hot: 10→100, 01→010, 00→001.
- FIN: `valido`=1 for exactly this cycle, then the FSM returns unconditionally to REPOSO.
- Results hold their value after `valido` until the next FIN overwrites them.
- `inicio` in COMPARA or FIN is ignored and not queued.
- Counter width is clog2(N)+1. It never wraps within an operation.
- Operands change during COMPARA with no effect; only the captured copies are used.

## Timing
- Reset values (after any edge with `rst_n`=0):
  - state = REPOSO;
  - `listo`=1, `valido`=0;
  - `mayor`=`igual`=`menor`=0;
  - pq=01; SA=SB=0; counter=0.
- Reset takes priority over every other event, including mid-COMPARA and in FIN. An aborted operation produces no `valido`.
- `listo` and `valido` are pure decodes of the registered state, with no combinational path from inputs.
- Latency, with `inicio` accepted at edge k:
  - bits 0..N-1 are processed at edges k+1..k+N;
  - results update and the FSM enters FIN at edge k+N;
  - `valido`=1 during the cycle between edges k+N and k+N+1;
  - `listo`=1 again from edge k+N+1.
- Throughput: one comparison per N+2 cycles. A new `inicio` can be accepted at edge k+N+2 at the earliest.
- For N=1: a single COMPARA cycle, with `valido` after edge k+1.

## Test plan
- Equal operands: N=8, A=B=0xA5, `inicio` at edge k. Expected: `listo`=0 from k, `valido` only in cycle k+8..k+9, outputs 010, `listo`=1 at k+9.
- MSB overrides lower bits: A=0x80, B=0x7F. Expected: pq is 00 through bits 0–6 and becomes 10 at bit 7, result 100. Then A=0x01, B=0x02, expected result 001.
- Ignored and held: pulse `inicio` with A=0x00, B=0xFF during COMPARA of A=0x10, B=0x10. Expected: result 010, exactly one `valido` pulse, outputs hold 010 for 20 idle cycles.
- Reset mid-operation: assert `rst_n`=0 at edge k+4 of an A=0xF0, B=0x0F run. Expected: next cycle REPOSO, `listo`=1, outputs 000, no `valido`. Then a new A=0x03, B=0x03 run gives 010.
- Back-to-back and edge values: `inicio` held high continuously with (0xFF,0xFE), then (0x00,0x00), then (0x00,0xFF). Expected: accepts at k, k+10, k+20, giving results 100, 010, 001.
- N=1 instance: all four (A,B) combinations. Expected: 010, 001, 100, 010, with `valido` one cycle after the single COMPARA cycle.
